id_stage: RTL

//  Decode stage directly downstream of instruction fetch. Owns the IF/ID register, a 32x32 register file and the ID/EX register.

---
 rtl/id_stage.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : RV32I decode stage. Holds the IF/ID register, a 32x32 register
//             file and the ID/EX register. Resolves branches/jumps in ID,
//             detects load-use and branch-operand hazards and stalls fetch.
//  Revision : 1.0  initial release
// ============================================================================
module id_stage #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            mem_reg_write,
  input  logic            mem_mem_read,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_fwd,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            pc_write,
  output logic            pc_src,
  output logic [XLEN-1:0] t_addr,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [31:0]     idex_inst,
  output logic [XLEN-1:0] idex_rs1_data,
  output logic [XLEN-1:0] idex_rs2_data,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd
);

  localparam logic [31:0] c_NOP       = 32'h0000_0013;
  localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  c_OP_REG    = 7'b0110011;
  localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;
  localparam logic [XLEN-1:0] c_FOUR  = XLEN'(4);
  localparam logic [XLEN-1:0] c_LSB0  = {{(XLEN-1){1'b1}}, 1'b0};

  // IF/ID register
  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_inst;

  // register file (entry 0 is never written)
  logic [XLEN-1:0] r_rf [NREG];

  // ID/EX register
  logic            r_idex_valid;
  logic [XLEN-1:0] r_idex_pc;
  logic [31:0]     r_idex_inst;
  logic [XLEN-1:0] r_idex_rs1_data;
  logic [XLEN-1:0] r_idex_rs2_data;
  logic [XLEN-1:0] r_idex_imm;
  logic [4:0]      r_idex_rs1;
  logic [4:0]      r_idex_rs2;
  logic [4:0]      r_idex_rd;

  // decode fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;

  // operands and hazard terms
  logic [XLEN-1:0] w_rs1_rd;
  logic [XLEN-1:0] w_rs2_rd;
  logic [XLEN-1:0] w_cmp1;
  logic [XLEN-1:0] w_cmp2;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_is_ctl;
  logic            w_ex_hit;
  logic            w_mem_hit;
  logic            w_load_use;
  logic            w_br_stall;
  logic            w_stall;
  logic            w_taken;
  logic            w_redirect;
  logic            w_pc_src;
  logic            w_fwd1;
  logic            w_fwd2;

  assign w_opcode = r_ifid_inst[6:0];
  assign w_rd     = r_ifid_inst[11:7];
  assign w_f3     = r_ifid_inst[14:12];
  assign w_rs1    = r_ifid_inst[19:15];
  assign w_rs2    = r_ifid_inst[24:20];

  // immediate selection by instruction format
  always_comb begin
    w_imm = '0;
    case (w_opcode)
      c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM:
        w_imm = {{20{r_ifid_inst[31]}}, r_ifid_inst[31:20]};
      c_OP_STORE:
        w_imm = {{20{r_ifid_inst[31]}}, r_ifid_inst[31:25], r_ifid_inst[11:7]};
      c_OP_BRANCH:
        w_imm = {{19{r_ifid_inst[31]}}, r_ifid_inst[31], r_ifid_inst[7],
                 r_ifid_inst[30:25], r_ifid_inst[11:8], 1'b0};
      c_OP_LUI, c_OP_AUIPC:
        w_imm = {r_ifid_inst[31:12], 12'b0};
      c_OP_JAL:
        w_imm = {{11{r_ifid_inst[31]}}, r_ifid_inst[31], r_ifid_inst[19:12],
                 r_ifid_inst[20], r_ifid_inst[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  // register file read ports: x0 reads zero, optional same-cycle WB bypass
  always_comb begin
    w_rs1_rd = r_rf[w_rs1];
    w_rs2_rd = r_rf[w_rs2];
    if (WB_BYPASS && wb_we && (wb_rd == w_rs1)) w_rs1_rd = wb_data;
    if (WB_BYPASS && wb_we && (wb_rd == w_rs2)) w_rs2_rd = wb_data;
    if (w_rs1 == 5'd0) w_rs1_rd = '0;
    if (w_rs2 == 5'd0) w_rs2_rd = '0;
  end

  // which source registers the instruction really consumes
  assign w_use_rs1 = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) ||
                       (w_opcode == c_OP_JAL));
  assign w_use_rs2 = (w_opcode == c_OP_REG) || (w_opcode == c_OP_STORE) ||
                     (w_opcode == c_OP_BRANCH);
  assign w_is_ctl  = (w_opcode == c_OP_BRANCH) || (w_opcode == c_OP_JALR);

  // producer-register matches against consumed sources; x0 never conflicts
  assign w_ex_hit  = (ex_rd != 5'd0) &&
                     ((w_use_rs1 && (ex_rd == w_rs1)) || (w_use_rs2 && (ex_rd == w_rs2)));
  assign w_mem_hit = (mem_rd != 5'd0) &&
                     ((w_use_rs1 && (mem_rd == w_rs1)) || (w_use_rs2 && (mem_rd == w_rs2)));

  // a load in EX feeding anything, or any EX result / MEM load feeding a
  // branch-side compare, is not yet available in ID
  assign w_load_use = r_ifid_valid && ex_mem_read && w_ex_hit;
  assign w_br_stall = r_ifid_valid && w_is_ctl &&
                      ((ex_reg_write && w_ex_hit) || (mem_mem_read && w_mem_hit));
  assign w_stall    = w_load_use || w_br_stall;

  // MEM-stage ALU results forward into the branch compare and JALR base
  assign w_fwd1 = mem_reg_write && !mem_mem_read && (mem_rd != 5'd0) && (mem_rd == w_rs1);
  assign w_fwd2 = mem_reg_write && !mem_mem_read && (mem_rd != 5'd0) && (mem_rd == w_rs2);
  assign w_cmp1 = w_fwd1 ? mem_fwd : w_rs1_rd;
  assign w_cmp2 = w_fwd2 ? mem_fwd : w_rs2_rd;

  // branch condition evaluation
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (w_cmp1 == w_cmp2);
      3'b001:  w_taken = (w_cmp1 != w_cmp2);
      3'b100:  w_taken = ($signed(w_cmp1) <  $signed(w_cmp2));
      3'b101:  w_taken = ($signed(w_cmp1) >= $signed(w_cmp2));
      3'b110:  w_taken = (w_cmp1 <  w_cmp2);
      3'b111:  w_taken = (w_cmp1 >= w_cmp2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_redirect = (w_opcode == c_OP_BRANCH) ? w_taken :
                      ((w_opcode == c_OP_JAL) || (w_opcode == c_OP_JALR));
  assign w_jalr_sum = w_cmp1 + w_imm;
  assign w_target   = (w_opcode == c_OP_JALR) ? (w_jalr_sum & c_LSB0)
                                              : (r_ifid_pc + w_imm);

  // a stall always wins over a redirect; IF/ID is invalid throughout reset,
  // so pc_write stays 1 and pc_src stays 0 while rst is low
  assign w_pc_src = r_ifid_valid && !w_stall && w_redirect;
  assign pc_src   = w_pc_src;
  assign pc_write = !w_stall;
  assign t_addr   = w_pc_src ? w_target : (r_ifid_pc + c_FOUR);

  // register file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // IF/ID register: hold on stall, squash on redirect, otherwise capture fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_inst  <= c_NOP;
    end else if (!w_stall) begin
      if (w_pc_src) begin
        r_ifid_valid <= 1'b0;
        r_ifid_pc    <= '0;
        r_ifid_inst  <= c_NOP;
      end else begin
        r_ifid_valid <= 1'b1;
        r_ifid_pc    <= if_pc;
        r_ifid_inst  <= if_inst;
      end
    end
  end

  // ID/EX register: issue the decoded instruction or an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idex_valid    <= 1'b0;
      r_idex_pc       <= '0;
      r_idex_inst     <= '0;
      r_idex_rs1_data <= '0;
      r_idex_rs2_data <= '0;
      r_idex_imm      <= '0;
      r_idex_rs1      <= '0;
      r_idex_rs2      <= '0;
      r_idex_rd       <= '0;
    end else if (r_ifid_valid && !w_stall) begin
      r_idex_valid    <= 1'b1;
      r_idex_pc       <= r_ifid_pc;
      r_idex_inst     <= r_ifid_inst;
      r_idex_rs1_data <= w_rs1_rd;
      r_idex_rs2_data <= w_rs2_rd;
      r_idex_imm      <= w_imm;
      r_idex_rs1      <= w_rs1;
      r_idex_rs2      <= w_rs2;
      r_idex_rd       <= w_rd;
    end else begin
      r_idex_valid    <= 1'b0;
      r_idex_pc       <= '0;
      r_idex_inst     <= '0;
      r_idex_rs1_data <= '0;
      r_idex_rs2_data <= '0;
      r_idex_imm      <= '0;
      r_idex_rs1      <= '0;
      r_idex_rs2      <= '0;
      r_idex_rd       <= '0;
    end
  end

  assign idex_valid    = r_idex_valid;
  assign idex_pc       = r_idex_pc;
  assign idex_inst     = r_idex_inst;
  assign idex_rs1_data = r_idex_rs1_data;
  assign idex_rs2_data = r_idex_rs2_data;
  assign idex_imm      = r_idex_imm;
  assign idex_rs1      = r_idex_rs1;
  assign idex_rs2      = r_idex_rs2;
  assign idex_rd       = r_idex_rd;

endmodule
`default_nettype wire
